// File: rtl/kronos_ex_sequencer_pkg.sv
// Shared types for the execute-stage sequencer.
//   ex_state_e : sequencer FSM states
//   sysop_e    : system-op encoding carried on instr_sysop (valid when instr_system)
//   Cause*     : exception codes produced by the sequencer itself
//   make_cause : builds the 32-bit mcause-style word {intr, 27'b0, code}
package kronos_ex_sequencer_pkg;

    typedef enum logic [2:0] {
        StSteady,
        StUnit,
        StTrap,
        StReturn,
        StWfintr,
        StJump
    } ex_state_e;

    typedef enum logic [1:0] {
        SysEcall  = 2'd0,
        SysEbreak = 2'd1,
        SysMret   = 2'd2,
        SysWfi    = 2'd3
    } sysop_e;

    localparam logic [3:0] CauseBreakpoint     = 4'd3;
    localparam logic [3:0] CauseEcallM         = 4'd11;
    localparam logic [3:0] CauseTimeoutDefault = 4'd5;

    function automatic logic [31:0] make_cause(input logic intr, input logic [3:0] code);
        return {intr, 27'b0, code};
    endfunction

endpackage

// File: rtl/kronos_ex_sequencer_watchdog.sv
// Stall watchdog for multi-cycle units.
//   clk, rstz : clock, synchronous active-low reset
//   clear_i   : restart the count (asserted on the cycle that enters UNIT)
//   run_i     : sequencer is in UNIT this cycle
//   expire_o  : this UNIT cycle is number TIMEOUT_CYCLES
// With TIMEOUT_CYCLES == 0 the watchdog is removed and expire_o is tied low.
module kronos_ex_sequencer_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic rstz,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = clk ^ rstz ^ clear_i ^ run_i;
            assign expire_o      = 1'b0;
        end else begin : g_on
            localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

            // count_q holds completed UNIT cycles, so the current cycle is count_q + 1.
            logic [CntW-1:0] count_q, count_d;

            always_comb begin
                count_d = count_q;
                if (clear_i) begin
                    count_d = '0;
                end else if (run_i) begin
                    count_d = count_q + CntW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rstz) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expire_o = run_i && (count_q == CntW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/kronos_ex_sequencer.sv
// Execute-stage sequencer: retires basic ALU ops, dispatches to multi-cycle units over
// vld/rdy, and sequences trap entry, MRET return, WFI and the CSR redirect handshake.
//   instr_*          : decoded instruction from the ID/EX register (held until instr_rdy)
//   interrupt*       : pending core interrupt and its code
//   unit_vld/rdy     : per-unit request / completion, unit_regwr/unit_data per-unit result
//   regwr_*          : registered register-file writeback
//   activate_trap    : high in TRAP, return_trap high in RETURN
//   trap_cause/value : registered cause word and tval for the CSR block
//   trap_jump        : CSR block finished the redirect
//   instret          : registered retire pulse
module kronos_ex_sequencer
    import kronos_ex_sequencer_pkg::*;
#(
    parameter int unsigned N_UNITS        = 3,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter logic [3:0]  TIMEOUT_CAUSE  = CauseTimeoutDefault
) (
    input  logic                    clk,
    input  logic                    rstz,
    input  logic                    instr_vld,
    output logic                    instr_rdy,
    input  logic [XLEN-1:0]         instr_pc,
    input  logic [N_UNITS-1:0]      instr_unit,
    input  logic [4:0]              instr_rd,
    input  logic                    instr_regwr,
    input  logic [XLEN-1:0]         basic_result,
    input  logic                    instr_exc,
    input  logic [3:0]              instr_exc_cause,
    input  logic [XLEN-1:0]         instr_exc_value,
    input  logic [1:0]              instr_sysop,
    input  logic                    instr_system,
    input  logic                    interrupt,
    input  logic [3:0]              interrupt_cause,
    output logic [N_UNITS-1:0]      unit_vld,
    input  logic [N_UNITS-1:0]      unit_rdy,
    input  logic [N_UNITS-1:0]      unit_regwr,
    input  logic [N_UNITS*XLEN-1:0] unit_data,
    output logic                    regwr_en,
    output logic [4:0]              regwr_sel,
    output logic [XLEN-1:0]         regwr_data,
    output logic                    activate_trap,
    output logic                    return_trap,
    output logic [31:0]             trap_cause,
    output logic [XLEN-1:0]         trap_value,
    input  logic                    trap_jump,
    output logic                    instret
);

    ex_state_e       state_q, state_d;
    logic            regwr_en_q, regwr_en_d;
    logic [4:0]      regwr_sel_q, regwr_sel_d;
    logic [XLEN-1:0] regwr_data_q, regwr_data_d;
    logic [31:0]     trap_cause_q, trap_cause_d;
    logic [XLEN-1:0] trap_value_q, trap_value_d;
    logic            instret_q, instret_d;
    // ECALL/EBREAK/MRET retire only once the redirect completes.
    logic            pending_q, pending_d;

    logic            wd_clear, wd_expire;
    logic [XLEN-1:0] unit_result;
    logic            sel_rdy, sel_regwr, is_unit;
    logic            is_ecall, is_ebreak, is_mret, is_wfi;
    sysop_e          sysop;

    // One-hot AND-OR select of the addressed unit's result.
    always_comb begin
        unit_result = '0;
        for (int unsigned i = 0; i < N_UNITS; i++) begin
            unit_result = unit_result | (unit_data[i*XLEN +: XLEN] & {XLEN{instr_unit[i]}});
        end
    end

    assign sel_rdy   = |(unit_rdy & instr_unit);
    assign sel_regwr = |(unit_regwr & instr_unit);
    assign is_unit   = |instr_unit;
    assign sysop     = sysop_e'(instr_sysop);
    assign is_ecall  = instr_system && (sysop == SysEcall);
    assign is_ebreak = instr_system && (sysop == SysEbreak);
    assign is_mret   = instr_system && (sysop == SysMret);
    assign is_wfi    = instr_system && (sysop == SysWfi);

    always_comb begin
        state_d      = state_q;
        instr_rdy    = 1'b0;
        unit_vld     = '0;
        wd_clear     = 1'b0;
        regwr_en_d   = 1'b0;
        regwr_sel_d  = regwr_sel_q;
        regwr_data_d = regwr_data_q;
        trap_cause_d = trap_cause_q;
        trap_value_d = trap_value_q;
        pending_d    = pending_q;

        case (state_q)
            StSteady: begin
                if (instr_vld) begin
                    if (interrupt) begin
                        state_d      = StTrap;
                        trap_cause_d = make_cause(1'b1, interrupt_cause);
                        trap_value_d = '0;
                    end else if (instr_exc) begin
                        state_d      = StTrap;
                        trap_cause_d = make_cause(1'b0, instr_exc_cause);
                        trap_value_d = instr_exc_value;
                    end else if (is_ecall) begin
                        state_d      = StTrap;
                        trap_cause_d = make_cause(1'b0, CauseEcallM);
                        trap_value_d = '0;
                        pending_d    = 1'b1;
                    end else if (is_ebreak) begin
                        state_d      = StTrap;
                        trap_cause_d = make_cause(1'b0, CauseBreakpoint);
                        trap_value_d = instr_pc;
                        pending_d    = 1'b1;
                    end else if (is_mret) begin
                        state_d   = StReturn;
                        pending_d = 1'b1;
                    end else if (is_wfi) begin
                        state_d = StWfintr;
                    end else if (is_unit) begin
                        unit_vld = instr_unit;
                        if (sel_rdy) begin
                            // Unit answered in the dispatch cycle: retire without UNIT.
                            instr_rdy    = 1'b1;
                            regwr_en_d   = sel_regwr;
                            regwr_sel_d  = instr_rd;
                            regwr_data_d = unit_result;
                        end else begin
                            state_d  = StUnit;
                            wd_clear = 1'b1;
                        end
                    end else begin
                        instr_rdy    = 1'b1;
                        regwr_en_d   = instr_regwr;
                        regwr_sel_d  = instr_rd;
                        regwr_data_d = basic_result;
                    end
                end
            end
            StUnit: begin
                unit_vld = instr_unit;
                // Completion on the terminal watchdog cycle takes precedence over the abort.
                if (sel_rdy) begin
                    state_d      = StSteady;
                    instr_rdy    = 1'b1;
                    regwr_en_d   = sel_regwr;
                    regwr_sel_d  = instr_rd;
                    regwr_data_d = unit_result;
                end else if (wd_expire) begin
                    state_d      = StTrap;
                    trap_cause_d = make_cause(1'b0, TIMEOUT_CAUSE);
                    trap_value_d = instr_pc;
                end
            end
            StWfintr: begin
                if (interrupt) begin
                    state_d      = StTrap;
                    trap_cause_d = make_cause(1'b1, interrupt_cause);
                    trap_value_d = '0;
                end
            end
            StTrap, StReturn: begin
                state_d = StJump;
            end
            StJump: begin
                if (trap_jump) begin
                    state_d   = StSteady;
                    pending_d = 1'b0;
                end
            end
            default: begin
                state_d = StSteady;
            end
        endcase
    end

    assign instret_d = (instr_vld && instr_rdy) || ((state_q == StJump) && trap_jump && pending_q);

    always_ff @(posedge clk) begin
        if (!rstz) begin
            state_q      <= StSteady;
            regwr_en_q   <= 1'b0;
            regwr_sel_q  <= '0;
            regwr_data_q <= '0;
            trap_cause_q <= '0;
            trap_value_q <= '0;
            instret_q    <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            regwr_en_q   <= regwr_en_d;
            regwr_sel_q  <= regwr_sel_d;
            regwr_data_q <= regwr_data_d;
            trap_cause_q <= trap_cause_d;
            trap_value_q <= trap_value_d;
            instret_q    <= instret_d;
            pending_q    <= pending_d;
        end
    end

    kronos_ex_sequencer_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rstz     (rstz),
        .clear_i  (wd_clear),
        .run_i    (state_q == StUnit),
        .expire_o (wd_expire)
    );

    assign regwr_en      = regwr_en_q;
    assign regwr_sel     = regwr_sel_q;
    assign regwr_data    = regwr_data_q;
    assign trap_cause    = trap_cause_q;
    assign trap_value    = trap_value_q;
    assign instret       = instret_q;
    assign activate_trap = (state_q == StTrap);
    assign return_trap   = (state_q == StReturn);

    a_unit_onehot0 : assert property (@(posedge clk) disable iff (!rstz)
        instr_vld |-> $onehot0(instr_unit));

    // Stray ready from unselected units is tolerated; the addressed unit must not
    // complete while it is not being requested.
    a_rdy_needs_vld : assert property (@(posedge clk) disable iff (!rstz)
        instr_vld |-> ((unit_rdy & instr_unit & ~unit_vld) == '0));

endmodule

// File: tb/tb_kronos_ex_sequencer.sv
module tb_kronos_ex_sequencer;
    import kronos_ex_sequencer_pkg::*;

    localparam int unsigned NU = 3;
    localparam int unsigned XL = 32;
    localparam int unsigned TO = 4;

    logic           clk = 1'b0;
    logic           rstz = 1'b0;
    logic           instr_vld, instr_rdy;
    logic [XL-1:0]  instr_pc, basic_result, instr_exc_value;
    logic [NU-1:0]  instr_unit, unit_vld, unit_rdy, unit_regwr;
    logic [4:0]     instr_rd, regwr_sel;
    logic           instr_regwr, instr_exc, instr_system, interrupt;
    logic [3:0]     instr_exc_cause, interrupt_cause;
    logic [1:0]     instr_sysop;
    logic [NU*XL-1:0] unit_data;
    logic           regwr_en, activate_trap, return_trap, trap_jump, instret;
    logic [XL-1:0]  regwr_data, trap_value;
    logic [31:0]    trap_cause;

    always #5 clk = ~clk;

    kronos_ex_sequencer #(
        .N_UNITS        (NU),
        .XLEN           (XL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rstz            (rstz),
        .instr_vld       (instr_vld),
        .instr_rdy       (instr_rdy),
        .instr_pc        (instr_pc),
        .instr_unit      (instr_unit),
        .instr_rd        (instr_rd),
        .instr_regwr     (instr_regwr),
        .basic_result    (basic_result),
        .instr_exc       (instr_exc),
        .instr_exc_cause (instr_exc_cause),
        .instr_exc_value (instr_exc_value),
        .instr_sysop     (instr_sysop),
        .instr_system    (instr_system),
        .interrupt       (interrupt),
        .interrupt_cause (interrupt_cause),
        .unit_vld        (unit_vld),
        .unit_rdy        (unit_rdy),
        .unit_regwr      (unit_regwr),
        .unit_data       (unit_data),
        .regwr_en        (regwr_en),
        .regwr_sel       (regwr_sel),
        .regwr_data      (regwr_data),
        .activate_trap   (activate_trap),
        .return_trap     (return_trap),
        .trap_cause      (trap_cause),
        .trap_value      (trap_value),
        .trap_jump       (trap_jump),
        .instret         (instret)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observed (monitor) and predicted (model) event streams.
    int got_instret = 0, exp_instret = 0;
    int got_ret = 0, exp_ret = 0;
    int got_uvld[NU];
    int exp_uvld[NU];
    logic [63:0] got_wb[$], exp_wb[$], got_trap[$], exp_trap[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstz) begin
            if (instret) got_instret <= got_instret + 1;
            if (return_trap) got_ret <= got_ret + 1;
            if (regwr_en) got_wb.push_back({27'b0, regwr_sel, regwr_data});
            if (activate_trap) got_trap.push_back({trap_cause, trap_value});
            for (int i = 0; i < NU; i++) begin
                if (unit_vld[i]) got_uvld[i] <= got_uvld[i] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_vld       = 1'b0;
        instr_pc        = '0;
        instr_unit      = '0;
        instr_rd        = '0;
        instr_regwr     = 1'b0;
        basic_result    = '0;
        instr_exc       = 1'b0;
        instr_exc_cause = '0;
        instr_exc_value = '0;
        instr_sysop     = '0;
        instr_system    = 1'b0;
        interrupt       = 1'b0;
        interrupt_cause = '0;
        unit_rdy        = '0;
        unit_regwr      = '0;
        unit_data       = '0;
        trap_jump       = 1'b0;
    endtask

    // Wait for TRAP/RETURN, then complete the redirect after a random JUMP delay.
    task automatic await_redirect();
        bit seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (activate_trap || return_trap) seen = 1'b1;
            else tick();
        end
        check_eq("redirect_seen", {63'b0, seen}, 64'd1);
        tick();
        repeat ($urandom_range(0, 2)) tick();
        trap_jump = 1'b1;
        tick();
        trap_jump = 1'b0;
    endtask

    task automatic do_basic(input logic [4:0] rd, input logic [31:0] res, input logic regwr);
        tick();
        idle_inputs();
        instr_vld    = 1'b1;
        instr_pc     = $urandom;
        instr_rd     = rd;
        basic_result = res;
        instr_regwr  = regwr;
        @(negedge clk);
        check_eq("basic_rdy", {63'b0, instr_rdy}, 64'd1);
        tick();
        instr_vld = 1'b0;
        @(negedge clk);
        check_eq("basic_wb_en", {63'b0, regwr_en}, {63'b0, regwr});
        check_eq("basic_instret", {63'b0, instret}, 64'd1);
        exp_instret++;
        if (regwr) exp_wb.push_back({27'b0, rd, res});
    endtask

    // lat = UNIT-relative cycle on which the unit answers (0 = dispatch cycle).
    task automatic do_unit(input int u, input int lat, input logic [31:0] data, input logic regwr,
                           input logic [4:0] rd, input logic [31:0] pc, input int stray);
        int last = (lat > TO) ? TO : lat;
        bit done = (lat <= TO);
        tick();
        idle_inputs();
        instr_vld  = 1'b1;
        instr_pc   = pc;
        instr_rd   = rd;
        instr_unit[u] = 1'b1;
        unit_data  = {$urandom, $urandom, $urandom};
        unit_data[u*XL +: XL] = data;
        unit_regwr = NU'($urandom);
        unit_regwr[u] = regwr;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) tick();
            unit_rdy = '0;
            if (c == lat) unit_rdy[u] = 1'b1;
            if (c == 1 && stray >= 0) unit_rdy[stray] = 1'b1;
            @(negedge clk);
            check_eq("unit_instr_rdy", {63'b0, instr_rdy}, {63'b0, (done && c == lat)});
        end
        tick();
        instr_vld = 1'b0;
        unit_rdy  = '0;
        exp_uvld[u] += last + 1;
        if (done) begin
            exp_instret++;
            if (regwr) exp_wb.push_back({27'b0, rd, data});
        end else begin
            exp_trap.push_back({32'd5, pc});
            await_redirect();
        end
    endtask

    // kind: 0 interrupt, 1 exception, 2 ECALL, 3 EBREAK, 4 MRET
    task automatic do_trap_instr(input int kind, input logic [31:0] pc);
        tick();
        idle_inputs();
        instr_vld = 1'b1;
        instr_pc  = pc;
        if (kind < 4 && $urandom_range(0, 1) == 1) instr_unit[$urandom_range(0, NU - 1)] = 1'b1;
        case (kind)
            0: begin
                interrupt       = 1'b1;
                interrupt_cause = 4'($urandom);
                instr_exc       = 1'($urandom);
                instr_system    = 1'($urandom);
                instr_sysop     = 2'($urandom);
                exp_trap.push_back({1'b1, 27'b0, interrupt_cause, 32'd0});
            end
            1: begin
                instr_exc       = 1'b1;
                instr_exc_cause = 4'($urandom);
                instr_exc_value = $urandom;
                instr_system    = 1'($urandom);
                instr_sysop     = 2'($urandom);
                exp_trap.push_back({28'b0, instr_exc_cause, instr_exc_value});
            end
            2: begin
                instr_system = 1'b1;
                instr_sysop  = SysEcall;
                exp_trap.push_back({32'd11, 32'd0});
                exp_instret++;
            end
            3: begin
                instr_system = 1'b1;
                instr_sysop  = SysEbreak;
                exp_trap.push_back({32'd3, pc});
                exp_instret++;
            end
            default: begin
                instr_system = 1'b1;
                instr_sysop  = SysMret;
                exp_ret++;
                exp_instret++;
            end
        endcase
        @(negedge clk);
        check_eq("trap_instr_rdy", {63'b0, instr_rdy}, 64'd0);
        check_eq("trap_unit_vld", {61'b0, unit_vld}, 64'd0);
        tick();
        idle_inputs();
        await_redirect();
    endtask

    task automatic do_wfi(input int delay, input logic [3:0] cause);
        tick();
        idle_inputs();
        instr_vld    = 1'b1;
        instr_pc     = $urandom;
        instr_system = 1'b1;
        instr_sysop  = SysWfi;
        @(negedge clk);
        check_eq("wfi_rdy", {63'b0, instr_rdy}, 64'd0);
        tick();
        idle_inputs();
        repeat (delay - 1) tick();
        @(negedge clk);
        check_eq("wfi_hold", {63'b0, activate_trap}, 64'd0);
        tick();
        interrupt       = 1'b1;
        interrupt_cause = cause;
        tick();
        interrupt = 1'b0;
        exp_trap.push_back({1'b1, 27'b0, cause, 32'd0});
        await_redirect();
    endtask

    task automatic reconcile();
        repeat (2) tick();
        check_eq("instret_cnt", 64'(got_instret), 64'(exp_instret));
        check_eq("return_cnt", 64'(got_ret), 64'(exp_ret));
        for (int u = 0; u < NU; u++) begin
            check_eq($sformatf("unit_vld%0d_cycles", u), 64'(got_uvld[u]), 64'(exp_uvld[u]));
        end
        check_eq("wb_cnt", 64'(got_wb.size()), 64'(exp_wb.size()));
        while (got_wb.size() > 0 && exp_wb.size() > 0) begin
            check_eq("wb_sel_data", got_wb.pop_front(), exp_wb.pop_front());
        end
        check_eq("trap_cnt", 64'(got_trap.size()), 64'(exp_trap.size()));
        while (got_trap.size() > 0 && exp_trap.size() > 0) begin
            check_eq("trap_cause_value", got_trap.pop_front(), exp_trap.pop_front());
        end
        got_wb.delete();
        exp_wb.delete();
        got_trap.delete();
        exp_trap.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NU; i++) begin
            got_uvld[i] = 0;
            exp_uvld[i] = 0;
        end
        idle_inputs();
        rstz = 1'b0;
        repeat (3) tick();
        rstz = 1'b1;
        @(negedge clk);
        check_eq("rst_instr_rdy", {63'b0, instr_rdy}, 64'd0);
        check_eq("rst_unit_vld", {61'b0, unit_vld}, 64'd0);
        check_eq("rst_regwr_en", {63'b0, regwr_en}, 64'd0);
        check_eq("rst_regwr_sel", {59'b0, regwr_sel}, 64'd0);
        check_eq("rst_regwr_data", {32'b0, regwr_data}, 64'd0);
        check_eq("rst_activate_trap", {63'b0, activate_trap}, 64'd0);
        check_eq("rst_return_trap", {63'b0, return_trap}, 64'd0);
        check_eq("rst_trap_cause", {32'b0, trap_cause}, 64'd0);
        check_eq("rst_trap_value", {32'b0, trap_value}, 64'd0);
        check_eq("rst_instret", {63'b0, instret}, 64'd0);

        do_basic(5'd5, 32'h1234, 1'b1);
        reconcile();
        do_unit(1, 3, 32'hCAFE, 1'b1, 5'd7, 32'h200, 0);
        reconcile();
        do_unit(2, 99, 32'hDEAD, 1'b1, 5'd9, 32'h300, -1);
        reconcile();
        do_unit(2, 4, 32'hBEEF, 1'b1, 5'd10, 32'h304, -1);
        reconcile();
        do_trap_instr(2, 32'h100);
        reconcile();
        do_wfi(10, 4'd7);
        reconcile();

        // Reset pulse while a unit is stalled.
        tick();
        idle_inputs();
        instr_vld  = 1'b1;
        instr_pc   = 32'h400;
        instr_rd   = 5'd3;
        instr_unit = 3'b100;
        unit_regwr = 3'b100;
        tick();
        tick();
        rstz = 1'b0;
        tick();
        rstz = 1'b1;
        instr_vld  = 1'b0;
        instr_unit = '0;
        @(negedge clk);
        check_eq("midrst_unit_vld", {61'b0, unit_vld}, 64'd0);
        check_eq("midrst_regwr_en", {63'b0, regwr_en}, 64'd0);
        check_eq("midrst_instret", {63'b0, instret}, 64'd0);
        exp_uvld[2] += 2;
        do_basic(5'd12, 32'h5A5A, 1'b1);
        reconcile();
        do_unit(2, 4, 32'h1111, 1'b1, 5'd13, 32'h408, -1);
        reconcile();

        for (int n = 0; n < 200; n++) begin
            int kind = $urandom_range(0, 8);
            int u    = $urandom_range(0, NU - 1);
            case (kind)
                0: do_basic(5'($urandom), $urandom, 1'($urandom));
                1, 2: do_unit(u, $urandom_range(0, 6), $urandom, 1'($urandom), 5'($urandom),
                              $urandom, ($urandom_range(0, 1) == 1) ? (u + 1) % NU : -1);
                3: do_trap_instr(0, $urandom);
                4: do_trap_instr(1, $urandom);
                5: do_trap_instr(2, $urandom);
                6: do_trap_instr(3, $urandom);
                7: do_trap_instr(4, $urandom);
                default: do_wfi($urandom_range(1, 12), 4'($urandom));
            endcase
            reconcile();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
